mp64_mmio_arbiter: RTL and testbench

Round-robin arbiter that serialises byte-wide MMIO transactions from all cores onto the single shared MMIO device port feeding the mailbox/spinlock block and other MMIO slaves. It latches one core's request and presents it downstream with the granting core's ID as `dev_requester_id`. It holds the request until the device acknowledges, then returns read data to that core. It guarantees exactly one device-side transaction per core request, so read side effects (spinlock acquire) occur once. A timeout converts a hung device into an error response.

---
 rtl/mp64_mmio_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mp64_mmio_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp64_mmio_arbiter.sv
// Round-robin arbiter serialising per-core byte MMIO transactions onto one shared device port.
// A hung device is turned into an 8'hFF read response plus a one-cycle error pulse.
module mp64_mmio_arbiter #(
    parameter int unsigned NUM_CORES    = 4,
    parameter int unsigned CORE_ID_BITS = 2,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CORES-1:0]      core_req,
    input  logic [NUM_CORES*12-1:0]   core_addr,
    input  logic [NUM_CORES*8-1:0]    core_wdata,
    input  logic [NUM_CORES-1:0]      core_wen,
    output logic [NUM_CORES*8-1:0]    core_rdata,
    output logic [NUM_CORES-1:0]      core_ack,
    output logic                      dev_req,
    output logic [11:0]               dev_addr,
    output logic [7:0]                dev_wdata,
    output logic                      dev_wen,
    output logic [CORE_ID_BITS-1:0]   dev_requester_id,
    input  logic [7:0]                dev_rdata,
    input  logic                      dev_ack,
    output logic                      err_valid,
    output logic [CORE_ID_BITS-1:0]   err_core
);

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    localparam logic [CNT_W-1:0]        CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CORE_ID_BITS-1:0] GRANT_RST = CORE_ID_BITS'(NUM_CORES - 1);

    logic [NUM_CORES-1:0][ADDR_W-1:0] addr_v;
    logic [NUM_CORES-1:0][DATA_W-1:0] wdata_v;

    logic [1:0]                       state_q, state_d;
    logic [CORE_ID_BITS-1:0]          last_grant_q, last_grant_d;
    logic [CORE_ID_BITS-1:0]          grant_q, grant_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic                             dev_req_q, dev_req_d;
    logic [ADDR_W-1:0]                dev_addr_q, dev_addr_d;
    logic [DATA_W-1:0]                dev_wdata_q, dev_wdata_d;
    logic                             dev_wen_q, dev_wen_d;
    logic [NUM_CORES-1:0][DATA_W-1:0] rdata_q, rdata_d;
    logic [NUM_CORES-1:0]             core_ack_q, core_ack_d;
    logic                             err_valid_q, err_valid_d;
    logic [CORE_ID_BITS-1:0]          err_core_q, err_core_d;

    logic [CORE_ID_BITS-1:0]          grant_c;
    logic [CORE_ID_BITS-1:0]          scan_idx;
    logic                             any_req_c;

    assign addr_v  = core_addr;
    assign wdata_v = core_wdata;

    // First requester after the last grant, wrapping modulo NUM_CORES.
    always_comb begin
        grant_c   = last_grant_q;
        any_req_c = 1'b0;
        scan_idx  = last_grant_q;
        for (int unsigned k = 1; k <= NUM_CORES; k++) begin
            scan_idx = CORE_ID_BITS'((32'(last_grant_q) + k) % NUM_CORES);
            if (!any_req_c && core_req[scan_idx]) begin
                grant_c   = scan_idx;
                any_req_c = 1'b1;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        dev_req_d    = dev_req_q;
        dev_addr_d   = dev_addr_q;
        dev_wdata_d  = dev_wdata_q;
        dev_wen_d    = dev_wen_q;
        rdata_d      = rdata_q;
        core_ack_d   = '0;
        err_valid_d  = 1'b0;
        err_core_d   = err_core_q;

        case (state_q)
            ST_IDLE: begin
                if (any_req_c) begin
                    grant_d     = grant_c;
                    dev_addr_d  = addr_v[grant_c];
                    dev_wdata_d = wdata_v[grant_c];
                    dev_wen_d   = core_wen[grant_c];
                    dev_req_d   = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (dev_ack) begin
                    rdata_d[grant_q]    = dev_rdata;
                    dev_req_d           = 1'b0;
                    core_ack_d[grant_q] = 1'b1;
                    state_d             = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d[grant_q]    = 8'hFF;
                    err_valid_d         = 1'b1;
                    err_core_d          = grant_q;
                    dev_req_d           = 1'b0;
                    core_ack_d[grant_q] = 1'b1;
                    state_d             = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                last_grant_d = grant_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_RST;
            grant_q      <= '0;
            cnt_q        <= '0;
            dev_req_q    <= 1'b0;
            dev_addr_q   <= '0;
            dev_wdata_q  <= '0;
            dev_wen_q    <= 1'b0;
            rdata_q      <= '0;
            core_ack_q   <= '0;
            err_valid_q  <= 1'b0;
            err_core_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            dev_req_q    <= dev_req_d;
            dev_addr_q   <= dev_addr_d;
            dev_wdata_q  <= dev_wdata_d;
            dev_wen_q    <= dev_wen_d;
            rdata_q      <= rdata_d;
            core_ack_q   <= core_ack_d;
            err_valid_q  <= err_valid_d;
            err_core_q   <= err_core_d;
        end
    end

    assign core_rdata       = rdata_q;
    assign core_ack         = core_ack_q;
    assign dev_req          = dev_req_q;
    assign dev_addr         = dev_addr_q;
    assign dev_wdata        = dev_wdata_q;
    assign dev_wen          = dev_wen_q;
    assign dev_requester_id = grant_q;
    assign err_valid        = err_valid_q;
    assign err_core         = err_core_q;

endmodule

// File: tb/tb_mp64_mmio_arbiter.sv
// Directed bench for mp64_mmio_arbiter: core and device agents, a cycle-stamped transaction
// model checked every cycle, and literal expectations for each scenario.
module tb_mp64_mmio_arbiter;

    localparam int unsigned NC  = 4;
    localparam int unsigned IDW = 2;
    localparam int unsigned TO  = 5;

    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  wdata;
        logic        wen;
    } txn_t;

    logic              clk        = 1'b0;
    logic              rst_n      = 1'b0;
    logic [NC-1:0]     core_req   = '0;
    logic [NC*12-1:0]  core_addr  = '0;
    logic [NC*8-1:0]   core_wdata = '0;
    logic [NC-1:0]     core_wen   = '0;
    logic [NC*8-1:0]   core_rdata;
    logic [NC-1:0]     core_ack;
    logic              dev_req;
    logic [11:0]       dev_addr;
    logic [7:0]        dev_wdata;
    logic              dev_wen;
    logic [IDW-1:0]    dev_requester_id;
    logic [7:0]        dev_rdata  = '0;
    logic              dev_ack    = 1'b0;
    logic              err_valid;
    logic [IDW-1:0]    err_core;

    mp64_mmio_arbiter #(.NUM_CORES(NC), .CORE_ID_BITS(IDW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_wen(core_wen), .core_rdata(core_rdata), .core_ack(core_ack),
        .dev_req(dev_req), .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_wen(dev_wen),
        .dev_requester_id(dev_requester_id), .dev_rdata(dev_rdata), .dev_ack(dev_ack),
        .err_valid(err_valid), .err_core(err_core)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Agent state: per-core transaction queues, device behaviour knobs, spinlock.
    txn_t        txq [NC][$];
    logic [NC-1:0] pop_pend  = '0;
    int unsigned ack_delay = 0;
    logic        hang      = 1'b0;
    int unsigned req_age   = 0;
    logic        lock      = 1'b0;
    int          lock_hits = 0;

    // Logs for the literal expectations.
    int          ack_cyc[$];
    int unsigned ack_core[$];
    int          err_cyc[$];
    int unsigned err_id[$];
    int unsigned dev_id_log[$];
    int unsigned dev_addr_log[$];
    int          req_hi = 0;

    initial begin : driver
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < int'(NC); i++) begin
                if (pop_pend[i]) begin
                    if (txq[i].size() > 0) txq[i].delete(0);
                    pop_pend[i] = 1'b0;
                end else if (core_ack[i]) begin
                    pop_pend[i] = 1'b1;
                end
                if (!pop_pend[i]) begin
                    if (txq[i].size() > 0) begin
                        core_req[i]            = 1'b1;
                        core_addr[i*12 +: 12]  = txq[i][0].addr;
                        core_wdata[i*8 +: 8]   = txq[i][0].wdata;
                        core_wen[i]            = txq[i][0].wen;
                    end else begin
                        core_req[i] = 1'b0;
                    end
                end
            end
            dev_ack   = dev_req && !hang && (req_age >= ack_delay);
            req_age   = dev_req ? req_age + 1 : 0;
            dev_rdata = (dev_addr == 12'h600) ? (lock ? 8'h00 : 8'h01) : (dev_addr[7:0] ^ 8'h0B);
        end
    end

    // Transaction-level model: each grant is stamped with its issue cycle and response cycle.
    logic        m_busy;
    int unsigned m_g, m_last, m_err_core;
    int          m_issue, m_resp;
    logic        m_to;
    logic [11:0] m_addr;
    logic [7:0]  m_wdata;
    logic        m_wen;
    logic [7:0]  m_rdata [NC];

    task automatic model_reset();
        m_busy = 1'b0; m_g = 0; m_last = NC - 1; m_err_core = 0;
        m_issue = 0; m_resp = -1; m_to = 1'b0;
        m_addr = '0; m_wdata = '0; m_wen = 1'b0;
        for (int i = 0; i < int'(NC); i++) m_rdata[i] = 8'h00;
    endtask

    initial begin : model
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else if (m_busy) begin
                if (cyc == m_resp) begin
                    m_last = m_g;
                    m_busy = 1'b0;
                end else if (m_resp < 0) begin
                    if (dev_ack) begin
                        m_resp = cyc + 1;
                        m_rdata[m_g] = dev_rdata;
                    end else if (cyc - m_issue + 1 >= int'(TO)) begin
                        m_resp = cyc + 1;
                        m_rdata[m_g] = 8'hFF;
                        m_to = 1'b1;
                        m_err_core = m_g;
                    end
                end
            end else begin
                for (int unsigned k = 1; k <= NC && !m_busy; k++) begin
                    int unsigned idx;
                    idx = (m_last + k) % NC;
                    if (core_req[idx]) begin
                        m_busy  = 1'b1;
                        m_g     = idx;
                        m_issue = cyc + 1;
                        m_resp  = -1;
                        m_to    = 1'b0;
                        m_addr  = core_addr[idx*12 +: 12];
                        m_wdata = core_wdata[idx*8 +: 8];
                        m_wen   = core_wen[idx];
                    end
                end
            end
        end
    end

    initial begin : compare
        forever begin
            logic        e_req, e_resp;
            @(negedge clk);
            e_req  = m_busy && cyc >= m_issue && (m_resp < 0 || cyc < m_resp);
            e_resp = m_busy && cyc == m_resp;
            chk("dev_req", 32'(dev_req), 32'(e_req));
            chk("dev_addr", 32'(dev_addr), 32'(m_addr));
            chk("dev_wdata", 32'(dev_wdata), 32'(m_wdata));
            chk("dev_wen", 32'(dev_wen), 32'(m_wen));
            chk("dev_requester_id", 32'(dev_requester_id), m_g);
            chk("core_ack", 32'(core_ack), e_resp ? (32'(1) << m_g) : 32'(0));
            chk("err_valid", 32'(err_valid), 32'(e_resp && m_to));
            chk("err_core", 32'(err_core), m_err_core);
            for (int i = 0; i < int'(NC); i++)
                chk($sformatf("core_rdata%0d", i), 32'(core_rdata[i*8 +: 8]), 32'(m_rdata[i]));
            if (dev_req && dev_ack) begin
                dev_id_log.push_back(32'(dev_requester_id));
                dev_addr_log.push_back(32'(dev_addr));
                if (dev_addr == 12'h600 && !dev_wen) begin
                    lock = 1'b1;
                    lock_hits++;
                end
            end
            if (dev_req) req_hi++;
            for (int i = 0; i < int'(NC); i++) begin
                if (core_ack[i]) begin
                    ack_cyc.push_back(cyc);
                    ack_core.push_back(i);
                end
            end
            if (err_valid) begin
                err_cyc.push_back(cyc);
                err_id.push_back(32'(err_core));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic clear_logs();
        ack_cyc.delete(); ack_core.delete(); err_cyc.delete(); err_id.delete();
        dev_id_log.delete(); dev_addr_log.delete(); req_hi = 0;
    endtask

    task automatic push(input int c, input logic [11:0] a, input logic [7:0] d, input logic w);
        txn_t t;
        t.addr = a; t.wdata = d; t.wen = w;
        txq[c].push_back(t);
    endtask

    function automatic logic pending();
        logic p;
        p = (core_req != '0) || dev_req || (core_ack != '0);
        for (int i = 0; i < int'(NC); i++) if (txq[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic wait_quiet(input string name, input int budget);
        int n;
        n = 0;
        while (pending() && n < budget) begin
            step(1);
            n++;
        end
        chk(name, 32'(n < budget), 32'(1));
        step(2);
    endtask

    task automatic wait_dev(input string name, input int unsigned id, input int budget);
        int n;
        n = 0;
        while (!(dev_req && 32'(dev_requester_id) == id) && n < budget) begin
            step(1);
            n++;
        end
        chk(name, 32'(n < budget), 32'(1));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t0;
        step(3);
        chk("rst_dev_req", 32'(dev_req), 32'(0));
        chk("rst_core_ack", 32'(core_ack), 32'(0));
        chk("rst_err_valid", 32'(err_valid), 32'(0));
        chk("rst_core_rdata", 32'(core_rdata), 32'(0));
        chk("rst_dev_id", 32'(dev_requester_id), 32'(0));
        chk("rst_dev_addr", 32'(dev_addr), 32'(0));
        rst_n = 1'b1;
        step(2);

        // Single read with same-cycle ack.
        clear_logs();
        t0 = cyc + 1;
        push(1, 12'h508, 8'h00, 1'b0);
        wait_quiet("single_wait", 50);
        chk("single_ack_count", ack_core.size(), 32'(1));
        chk("single_ack_core", ack_core[0], 32'(1));
        chk("single_ack_cycle", 32'(ack_cyc[0]), 32'(t0 + 2));
        chk("single_rdata", 32'(core_rdata[15:8]), 32'(8'h03));
        chk("single_req_cycles", 32'(req_hi), 32'(1));
        chk("single_dev_id", dev_id_log[0], 32'(1));
        chk("single_dev_addr", dev_addr_log[0], 32'(12'h508));

        // All cores request out of reset and re-request straight after each ack.
        rst_n = 1'b0;
        step(2);
        clear_logs();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < int'(NC); i++)
                push(i, 12'(12'h100 + 16 * i + r), 8'(8'h30 + i), 1'b0);
        step(1);
        rst_n = 1'b1;
        wait_quiet("simul_wait", 200);
        chk("simul_ack_count", ack_core.size(), 32'(8));
        for (int j = 0; j < 5; j++)
            chk($sformatf("simul_order%0d", j), ack_core[j], 32'(j % 4));
        for (int j = 1; j < 5; j++)
            chk($sformatf("simul_spacing%0d", j), 32'(ack_cyc[j] - ack_cyc[j-1]), 32'(3));

        // Spinlock: both readers hit the device exactly once each.
        lock = 1'b0;
        lock_hits = 0;
        clear_logs();
        push(0, 12'h600, 8'h00, 1'b0);
        push(2, 12'h600, 8'h00, 1'b0);
        wait_quiet("spin_wait", 100);
        chk("spin_device_hits", 32'(lock_hits), 32'(2));
        chk("spin_ack_count", ack_core.size(), 32'(2));
        chk("spin_first_id", dev_id_log[0], 32'(0));
        chk("spin_second_id", dev_id_log[1], 32'(2));
        chk("spin_rdata0", 32'(core_rdata[7:0]), 32'(8'h01));
        chk("spin_rdata2", 32'(core_rdata[23:16]), 32'(8'h00));

        // Rotation after a grant to core 2, device acking 2 cycles late.
        ack_delay = 2;
        clear_logs();
        t0 = cyc + 1;
        push(2, 12'h2A0, 8'h5C, 1'b1);
        wait_dev("rot_wait_issue", 2, 20);
        push(1, 12'h2A1, 8'h00, 1'b0);
        push(3, 12'h2A3, 8'h00, 1'b0);
        wait_quiet("rot_wait", 100);
        chk("rot_ack_count", ack_core.size(), 32'(3));
        chk("rot_order0", ack_core[0], 32'(2));
        chk("rot_order1", ack_core[1], 32'(3));
        chk("rot_order2", ack_core[2], 32'(1));
        chk("rot_delayed_ack_cycle", 32'(ack_cyc[0]), 32'(t0 + 4));

        // Timeout on a write from core 3.
        ack_delay = 0;
        hang = 1'b1;
        clear_logs();
        t0 = cyc + 1;
        push(3, 12'h123, 8'hA5, 1'b1);
        wait_quiet("to_wait", 100);
        hang = 1'b0;
        chk("to_req_cycles", 32'(req_hi), 32'(TO));
        chk("to_rdata3", 32'(core_rdata[31:24]), 32'(8'hFF));
        chk("to_err_count", err_cyc.size(), 32'(1));
        chk("to_err_core", err_id[0], 32'(3));
        chk("to_err_with_ack", 32'(err_cyc[0]), 32'(ack_cyc[0]));
        chk("to_ack_cycle", 32'(ack_cyc[0]), 32'(t0 + int'(TO) + 1));
        chk("to_no_device_ack", dev_id_log.size(), 32'(0));

        // Reset while core 2 is stalled in ISSUE; last grant before it was core 2.
        clear_logs();
        push(2, 12'h050, 8'h11, 1'b1);
        wait_quiet("rst_prep_wait", 50);
        hang = 1'b1;
        clear_logs();
        push(2, 12'h060, 8'h22, 1'b1);
        wait_dev("rst_wait_issue", 2, 20);
        step(2);
        rst_n = 1'b0;
        #1;
        chk("rst_async_dev_req", 32'(dev_req), 32'(0));
        txq[2].delete();
        pop_pend = '0;
        hang = 1'b0;
        step(2);
        rst_n = 1'b1;
        chk("rst_no_ack", ack_core.size(), 32'(0));
        chk("rst_no_err", err_cyc.size(), 32'(0));
        clear_logs();
        push(0, 12'h070, 8'h00, 1'b0);
        push(3, 12'h073, 8'h00, 1'b0);
        wait_quiet("rst_after_wait", 100);
        chk("rst_after_first_grant", ack_core[0], 32'(0));
        chk("rst_after_second_grant", ack_core[1], 32'(3));

        step(3);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
